// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared widths, x0 index and writeback/MDU entry types.
package wb_port_arbiter_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int XLEN = 32;
   localparam logic [REG_ADDR_W-1:0] X0 = '0;
   typedef struct packed {
      logic                  we;
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } mdu_entry_t;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: WB/MDU/decode/register-file signals around the write-port arbiter.
interface wb_port_arbiter_if;
   import wb_port_arbiter_pkg::*;
   logic                  pipe_regwrite;
   logic [REG_ADDR_W-1:0] pipe_rd;
   logic [XLEN-1:0]       pipe_result;
   logic                  wb_stall;
   logic                  issue_valid;
   logic [REG_ADDR_W-1:0] issue_rd;
   logic                  issue_ready;
   logic                  mdu_valid;
   logic [REG_ADDR_W-1:0] mdu_rd;
   logic [XLEN-1:0]       mdu_result;
   logic                  mdu_ready;
   logic [REG_ADDR_W-1:0] dec_rs1;
   logic [REG_ADDR_W-1:0] dec_rs2;
   logic [REG_ADDR_W-1:0] dec_rd;
   logic                  raw_stall;
   logic                  rf_we;
   logic [REG_ADDR_W-1:0] rf_rd;
   logic [XLEN-1:0]       rf_wdata;
   modport slave (
      input  pipe_regwrite, pipe_rd, pipe_result, issue_valid, issue_rd,
             mdu_valid, mdu_rd, mdu_result, dec_rs1, dec_rs2, dec_rd,
      output wb_stall, issue_ready, mdu_ready, raw_stall, rf_we, rf_rd, rf_wdata
   );
   modport master (
      output pipe_regwrite, pipe_rd, pipe_result, issue_valid, issue_rd,
             mdu_valid, mdu_rd, mdu_result, dec_rs1, dec_rs2, dec_rd,
      input  wb_stall, issue_ready, mdu_ready, raw_stall, rf_we, rf_rd, rf_wdata
   );
endinterface

// File: rtl/wb_port_arbiter_result_fifo.sv
// wb_result_fifo: small power-of-two FIFO holding MDU results until they win the write port.
module wb_result_fifo
   import wb_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_push,
   input  mdu_entry_t i_data,
   input  logic       i_pop,
   output mdu_entry_t o_head,
   output logic       o_full,
   output logic       o_empty
);
   localparam int AW = $clog2(DEPTH);
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   mdu_entry_t    r_mem [DEPTH];
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end
   assign o_head  = r_mem[r_rd_ptr];
   assign o_full  = r_count == (AW+1)'(DEPTH);
   assign o_empty = r_count == '0;
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the WB stage and the MDU,
// with a starvation guard on buffered MDU results and a busy scoreboard for MDU destinations.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input logic               clk,
   input logic               reset,
   wb_port_arbiter_if.slave  bus
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
   logic        w_full;
   logic        w_empty;
   logic        w_pipe_req;
   logic        w_force;
   logic        w_grant_mdu;
   logic        w_grant_pipe;
   logic        w_issue_ready;
   logic [31:0] w_set;
   logic [31:0] w_clr;
   mdu_entry_t  w_head;
   wb_req_t     w_req;
   logic [SW-1:0] r_starve;
   logic [31:0]   r_busy;
   wb_req_t       r_out;
   wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (bus.mdu_valid & ~w_full),
      .i_data  ('{rd: bus.mdu_rd, data: bus.mdu_result}),
      .i_pop   (w_grant_mdu),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );
   assign w_pipe_req    = bus.pipe_regwrite & (bus.pipe_rd != X0);
   assign w_force       = ~w_empty & (r_starve == LIMIT);
   assign w_grant_mdu   = ~w_empty & (~w_pipe_req | w_force);
   assign w_grant_pipe  = w_pipe_req & ~w_grant_mdu;
   assign w_issue_ready = ~r_busy[bus.issue_rd];
   // Reset gates the stall so upstream never sees a hold while the FIFO is being flushed.
   assign bus.wb_stall    = w_pipe_req & w_grant_mdu & ~reset;
   assign bus.issue_ready = w_issue_ready;
   assign bus.mdu_ready   = ~w_full;
   assign bus.raw_stall   = r_busy[bus.dec_rs1] | r_busy[bus.dec_rs2] | r_busy[bus.dec_rd];
   assign bus.rf_we       = r_out.we;
   assign bus.rf_rd       = r_out.rd;
   assign bus.rf_wdata    = r_out.data;
   always_comb begin
      w_req.we   = w_grant_pipe | (w_grant_mdu & (w_head.rd != X0));
      w_req.rd   = w_grant_mdu ? w_head.rd : bus.pipe_rd;
      w_req.data = w_grant_mdu ? w_head.data : bus.pipe_result;
      w_set = (bus.issue_valid & w_issue_ready & (bus.issue_rd != X0)) ? 32'd1 << bus.issue_rd : '0;
      w_clr = w_grant_mdu ? 32'd1 << w_head.rd : '0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out <= '0;
      end else begin
         r_out.we <= w_req.we;
         if (w_req.we) begin
            r_out.rd   <= w_req.rd;
            r_out.data <= w_req.data;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset || w_empty || w_grant_mdu) r_starve <= '0;
      else if (w_grant_pipe && r_starve != LIMIT) r_starve <= r_starve + SW'(1);
   end
   // Bit 0 is never set, so x0 reads as not busy everywhere.
   always_ff @(posedge clk) begin
      if (reset) r_busy <= '0;
      else r_busy <= (r_busy | w_set) & ~w_clr;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (bus.mdu_valid && !w_full && bus.mdu_rd != X0) assert (r_busy[bus.mdu_rd]);
         if (w_pipe_req) assert (!r_busy[bus.pipe_rd]);
      end
   end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenarios plus constrained-random traffic against a queue-based model.
module tb_wb_port_arbiter;
   localparam int DEPTH = 2;
   localparam int STARVE_LIMIT = 4;
   typedef struct packed { logic [4:0] rd; logic [31:0] d; } ent_t;
   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail = 0;
   ent_t        m_q[$];
   bit [31:0]   m_busy = '0;
   int          m_starve = 0;
   bit          m_we = 0;
   logic [4:0]  m_rd = '0;
   logic [31:0] m_wd = '0;
   bit          m_pipe_held = 0;
   bit          m_mdu_held = 0;
   wb_port_arbiter_if bus();
   wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   function automatic bit m_preq();
      return bus.pipe_regwrite && bus.pipe_rd != 5'd0;
   endfunction
   function automatic bit m_gmdu();
      return m_q.size() > 0 && (!m_preq() || m_starve == STARVE_LIMIT);
   endfunction
   task automatic tick();
      bit pr, gm, acc;
      int n;
      ent_t e;
      @(negedge clk);
      if (reset) begin
         m_q.delete(); m_busy = '0; m_starve = 0; m_we = 0; m_rd = '0; m_wd = '0;
         m_pipe_held = 0; m_mdu_held = 0;
      end else begin
         pr = m_preq(); gm = m_gmdu(); n = m_q.size();
         acc = bus.issue_valid && bus.issue_rd != 5'd0 && !m_busy[bus.issue_rd];
         m_pipe_held = pr && gm;
         m_mdu_held = bus.mdu_valid && n == DEPTH;
         if (gm) begin
            e = m_q.pop_front();
            m_we = e.rd != 5'd0;
            if (m_we) begin m_rd = e.rd; m_wd = e.d; m_busy[e.rd] = 0; end
            m_starve = 0;
         end else if (pr) begin
            m_we = 1; m_rd = bus.pipe_rd; m_wd = bus.pipe_result;
            m_starve = (n == 0) ? 0 : (m_starve < STARVE_LIMIT ? m_starve + 1 : m_starve);
         end else begin
            m_we = 0; m_starve = 0;
         end
         if (acc) m_busy[bus.issue_rd] = 1;
         if (bus.mdu_valid && n < DEPTH) m_q.push_back('{bus.mdu_rd, bus.mdu_result});
      end
      @(posedge clk); #1;
   endtask
   task automatic idle();
      bus.pipe_regwrite = 0; bus.pipe_rd = '0; bus.pipe_result = '0;
      bus.issue_valid = 0; bus.issue_rd = '0;
      bus.mdu_valid = 0; bus.mdu_rd = '0; bus.mdu_result = '0;
      bus.dec_rs1 = '0; bus.dec_rs2 = '0; bus.dec_rd = '0;
   endtask
   task automatic issue(input logic [4:0] rd);
      bus.issue_valid = 1; bus.issue_rd = rd; tick(); bus.issue_valid = 0;
   endtask
   task automatic test_reset();
      reset = 1; idle(); tick();
      bus.pipe_regwrite = 1; bus.pipe_rd = 5'd4; #1;
      n_checks++; if (bus.wb_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.wb_stall); end
      tick(); idle(); bus.issue_rd = 5'd5; #1;
      n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", bus.rf_we); end
      n_checks++; if (bus.rf_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd got %0d want 0", bus.rf_rd); end
      n_checks++; if (bus.rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", bus.rf_wdata); end
      n_checks++; if (bus.mdu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mdu_ready got %b want 1", bus.mdu_ready); end
      n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready got %b want 1", bus.issue_ready); end
      reset = 0;
   endtask
   task automatic test_pipe_write();
      bus.pipe_regwrite = 1; bus.pipe_rd = 5'd3; bus.pipe_result = 32'hDEADBEEF; tick();
      bus.pipe_rd = 5'd0; bus.pipe_result = 32'h1;
      n_checks++; if ({bus.rf_we, bus.rf_rd, bus.rf_wdata} !== {1'b1, 5'd3, 32'hDEADBEEF}) begin
         n_fail++; $display("FAIL pipe_write got we=%b rd=%0d d=%h want we=1 rd=3 d=deadbeef", bus.rf_we, bus.rf_rd, bus.rf_wdata); end
      tick(); bus.pipe_regwrite = 0;
      n_checks++; if ({bus.rf_we, bus.rf_rd, bus.rf_wdata} !== {1'b0, 5'd3, 32'hDEADBEEF}) begin
         n_fail++; $display("FAIL pipe_x0 got we=%b rd=%0d d=%h want we=0 rd=3 d=deadbeef", bus.rf_we, bus.rf_rd, bus.rf_wdata); end
   endtask
   task automatic test_issue_complete();
      bus.issue_valid = 1; bus.issue_rd = 5'd7; #1;
      n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL issue_ready7 got %b want 1", bus.issue_ready); end
      tick(); bus.dec_rs2 = 5'd7; #1;
      n_checks++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL issue_ready7_busy got %b want 0", bus.issue_ready); end
      n_checks++; if (bus.raw_stall !== 1'b1) begin n_fail++; $display("FAIL raw_rs2_7 got %b want 1", bus.raw_stall); end
      tick(); bus.issue_valid = 0;
      bus.mdu_valid = 1; bus.mdu_rd = 5'd7; bus.mdu_result = 32'h12; tick(); bus.mdu_valid = 0; #1;
      n_checks++; if (bus.raw_stall !== 1'b1) begin n_fail++; $display("FAIL raw_grant_cycle got %b want 1", bus.raw_stall); end
      tick();
      n_checks++; if ({bus.rf_we, bus.rf_rd, bus.rf_wdata} !== {1'b1, 5'd7, 32'h12}) begin
         n_fail++; $display("FAIL mdu_write7 got we=%b rd=%0d d=%h want we=1 rd=7 d=12", bus.rf_we, bus.rf_rd, bus.rf_wdata); end
      n_checks++; if (bus.raw_stall !== 1'b0) begin n_fail++; $display("FAIL raw_cleared got %b want 0", bus.raw_stall); end
      bus.dec_rs2 = '0;
   endtask
   task automatic test_starvation();
      issue(5'd9);
      bus.mdu_valid = 1; bus.mdu_rd = 5'd9; bus.mdu_result = 32'h99; tick(); bus.mdu_valid = 0;
      for (int k = 0; k < 4; k++) begin
         bus.pipe_regwrite = 1; bus.pipe_rd = 5'(10 + k); bus.pipe_result = 32'h100 + k; #1;
         n_checks++; if (bus.wb_stall !== 1'b0) begin n_fail++; $display("FAIL starve_win%0d got stall=%b want 0", k, bus.wb_stall); end
         tick();
         n_checks++; if ({bus.rf_we, bus.rf_rd} !== {1'b1, 5'(10 + k)}) begin
            n_fail++; $display("FAIL starve_pipe%0d got we=%b rd=%0d want rd=%0d", k, bus.rf_we, bus.rf_rd, 10 + k); end
      end
      bus.pipe_rd = 5'd14; bus.pipe_result = 32'h104; #1;
      n_checks++; if (bus.wb_stall !== 1'b1) begin n_fail++; $display("FAIL starve_force got stall=%b want 1", bus.wb_stall); end
      tick(); #1;
      n_checks++; if ({bus.rf_we, bus.rf_rd, bus.rf_wdata} !== {1'b1, 5'd9, 32'h99}) begin
         n_fail++; $display("FAIL starve_mdu got we=%b rd=%0d d=%h want rd=9 d=99", bus.rf_we, bus.rf_rd, bus.rf_wdata); end
      n_checks++; if (bus.wb_stall !== 1'b0) begin n_fail++; $display("FAIL starve_release got stall=%b want 0", bus.wb_stall); end
      tick(); bus.pipe_regwrite = 0;
      n_checks++; if ({bus.rf_we, bus.rf_rd, bus.rf_wdata} !== {1'b1, 5'd14, 32'h104}) begin
         n_fail++; $display("FAIL starve_held got we=%b rd=%0d d=%h want rd=14 d=104", bus.rf_we, bus.rf_rd, bus.rf_wdata); end
   endtask
   task automatic test_fifo_full();
      issue(5'd11); issue(5'd12); issue(5'd13);
      bus.pipe_regwrite = 1; bus.pipe_rd = 5'd20; bus.pipe_result = 32'hA0;
      bus.mdu_valid = 1; bus.mdu_rd = 5'd11; bus.mdu_result = 32'hB1; tick();
      bus.mdu_rd = 5'd12; bus.mdu_result = 32'hB2; tick();
      bus.mdu_rd = 5'd13; bus.mdu_result = 32'hB3;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++; if ({bus.mdu_ready, bus.wb_stall} !== 2'b00) begin
            n_fail++; $display("FAIL full_hold%0d got ready=%b stall=%b want 0 0", i, bus.mdu_ready, bus.wb_stall); end
         tick();
      end
      #1;
      n_checks++; if ({bus.mdu_ready, bus.wb_stall} !== 2'b01) begin
         n_fail++; $display("FAIL full_pop got ready=%b stall=%b want 0 1", bus.mdu_ready, bus.wb_stall); end
      tick(); #1;
      n_checks++; if (bus.mdu_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_back got %b want 1", bus.mdu_ready); end
      n_checks++; if ({bus.rf_we, bus.rf_rd, bus.rf_wdata} !== {1'b1, 5'd11, 32'hB1}) begin
         n_fail++; $display("FAIL full_w11 got we=%b rd=%0d d=%h", bus.rf_we, bus.rf_rd, bus.rf_wdata); end
      tick(); bus.mdu_valid = 0; bus.pipe_regwrite = 0;
      n_checks++; if ({bus.rf_we, bus.rf_rd} !== {1'b1, 5'd20}) begin n_fail++; $display("FAIL full_pipe got we=%b rd=%0d want rd=20", bus.rf_we, bus.rf_rd); end
      tick();
      n_checks++; if ({bus.rf_we, bus.rf_rd, bus.rf_wdata} !== {1'b1, 5'd12, 32'hB2}) begin
         n_fail++; $display("FAIL full_w12 got we=%b rd=%0d d=%h", bus.rf_we, bus.rf_rd, bus.rf_wdata); end
      tick();
      n_checks++; if ({bus.rf_we, bus.rf_rd, bus.rf_wdata} !== {1'b1, 5'd13, 32'hB3}) begin
         n_fail++; $display("FAIL full_w13 got we=%b rd=%0d d=%h", bus.rf_we, bus.rf_rd, bus.rf_wdata); end
      tick();
      n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL full_no_dup got we=%b want 0", bus.rf_we); end
   endtask
   task automatic test_x0_result();
      bus.mdu_valid = 1; bus.mdu_rd = 5'd0; bus.mdu_result = 32'h55; tick(); bus.mdu_valid = 0;
      tick();
      n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_we got %b want 0", bus.rf_we); end
      bus.pipe_regwrite = 1; bus.pipe_rd = 5'd15; bus.pipe_result = 32'h15; #1;
      n_checks++; if ({bus.wb_stall, bus.mdu_ready} !== 2'b01) begin
         n_fail++; $display("FAIL x0_popped got stall=%b ready=%b want 0 1", bus.wb_stall, bus.mdu_ready); end
      tick(); bus.pipe_regwrite = 0;
      n_checks++; if ({bus.rf_we, bus.rf_rd} !== {1'b1, 5'd15}) begin n_fail++; $display("FAIL x0_next got we=%b rd=%0d want rd=15", bus.rf_we, bus.rf_rd); end
   endtask
   task automatic test_reset_mid();
      issue(5'd5); issue(5'd6); issue(5'd8);
      bus.pipe_regwrite = 1; bus.pipe_rd = 5'd20; bus.pipe_result = 32'h1;
      bus.mdu_valid = 1; bus.mdu_rd = 5'd6; bus.mdu_result = 32'h6; tick();
      bus.mdu_rd = 5'd8; bus.mdu_result = 32'h8; tick(); bus.mdu_valid = 0; #1;
      n_checks++; if (bus.mdu_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full got ready=%b want 0", bus.mdu_ready); end
      reset = 1; #1;
      n_checks++; if (bus.wb_stall !== 1'b0) begin n_fail++; $display("FAIL mid_stall got %b want 0", bus.wb_stall); end
      tick(); reset = 0; bus.pipe_regwrite = 0; bus.dec_rs1 = 5'd5; bus.issue_rd = 5'd6; #1;
      n_checks++; if ({bus.rf_we, bus.mdu_ready, bus.raw_stall, bus.issue_ready} !== 4'b0101) begin
         n_fail++; $display("FAIL mid_after got we=%b ready=%b raw=%b iready=%b want 0 1 0 1", bus.rf_we, bus.mdu_ready, bus.raw_stall, bus.issue_ready); end
      tick();
      n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_flushed got we=%b want 0", bus.rf_we); end
      bus.dec_rs1 = '0;
   endtask
   task automatic test_random();
      int pend[$];
      bit inq;
      logic [4:0] r;
      for (int c = 0; c < 600; c++) begin
         if (!m_pipe_held) begin
            r = 5'($urandom_range(0, 31));
            bus.pipe_regwrite = ($urandom_range(0, 3) != 0);
            bus.pipe_rd = m_busy[r] ? 5'd0 : r;
            bus.pipe_result = $urandom;
         end
         if (!m_mdu_held) begin
            pend.delete();
            for (int k = 1; k < 32; k++) begin
               inq = 0;
               foreach (m_q[j]) if (m_q[j].rd == 5'(k)) inq = 1;
               if (m_busy[k] && !inq) pend.push_back(k);
            end
            bus.mdu_valid = 0;
            if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
               bus.mdu_valid = 1; bus.mdu_rd = 5'(pend[$urandom_range(0, pend.size() - 1)]);
            end else if ($urandom_range(0, 9) == 0) begin
               bus.mdu_valid = 1; bus.mdu_rd = 5'd0;
            end
            bus.mdu_result = $urandom;
         end
         bus.issue_rd = 5'($urandom_range(0, 31));
         bus.issue_valid = ($urandom_range(0, 2) == 0) && !(bus.pipe_regwrite && bus.issue_rd == bus.pipe_rd);
         bus.dec_rs1 = 5'($urandom_range(0, 31)); bus.dec_rs2 = 5'($urandom_range(0, 31)); bus.dec_rd = 5'($urandom_range(0, 31));
         #1;
         n_checks++; if (bus.wb_stall !== (m_preq() && m_gmdu())) begin
            n_fail++; $display("FAIL rnd_stall c=%0d got %b want %b", c, bus.wb_stall, m_preq() && m_gmdu()); end
         n_checks++; if (bus.mdu_ready !== (m_q.size() < DEPTH)) begin
            n_fail++; $display("FAIL rnd_mdu_ready c=%0d got %b want %b", c, bus.mdu_ready, m_q.size() < DEPTH); end
         n_checks++; if (bus.issue_ready !== !m_busy[bus.issue_rd]) begin
            n_fail++; $display("FAIL rnd_issue_ready c=%0d got %b want %b", c, bus.issue_ready, !m_busy[bus.issue_rd]); end
         n_checks++; if (bus.raw_stall !== (m_busy[bus.dec_rs1] | m_busy[bus.dec_rs2] | m_busy[bus.dec_rd])) begin
            n_fail++; $display("FAIL rnd_raw c=%0d got %b", c, bus.raw_stall); end
         tick();
         n_checks++; if ({bus.rf_we, bus.rf_rd, bus.rf_wdata} !== {m_we, m_rd, m_wd}) begin
            n_fail++; $display("FAIL rnd_rf c=%0d got we=%b rd=%0d d=%h want we=%b rd=%0d d=%h", c, bus.rf_we, bus.rf_rd, bus.rf_wdata, m_we, m_rd, m_wd); end
      end
      idle();
   endtask
   initial begin
      test_reset();
      test_pipe_write();
      test_issue_complete();
      test_starvation();
      test_fifo_full();
      test_x0_result();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end
endmodule
